difftest_arch_state: RTL and testbench

DIFFTEST_ARCH_STATE -- requirements
Module: difftest_arch_state

---
 rtl/difftest_arch_state_pkg.sv | 39 +++
 rtl/difftest_regbank.sv | 47 ++++
 rtl/difftest_arch_state.sv | 146 ++++++++++++++
 tb/tb_difftest_arch_state.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/difftest_arch_state_pkg.sv
// Shared definitions for the difftest architectural-state snapshot block.
// Holds the default data width and register count, the CSR slot numbering
// used by the CSR bank, and the rd_sel region bases used by the read mux.
package difftest_arch_state_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREG_DEF  = 32;
  localparam int CSR_SLOTS = 18;

  // CSR slot numbering, matching the order of the CSR input ports.
  typedef enum logic [4:0] {
    CSR_PRIV     = 5'd0,
    CSR_MSTATUS  = 5'd1,
    CSR_SSTATUS  = 5'd2,
    CSR_MEPC     = 5'd3,
    CSR_SEPC     = 5'd4,
    CSR_MTVAL    = 5'd5,
    CSR_STVAL    = 5'd6,
    CSR_MTVEC    = 5'd7,
    CSR_STVEC    = 5'd8,
    CSR_MCAUSE   = 5'd9,
    CSR_SCAUSE   = 5'd10,
    CSR_SATP     = 5'd11,
    CSR_MIP      = 5'd12,
    CSR_MIE      = 5'd13,
    CSR_MSCRATCH = 5'd14,
    CSR_SSCRATCH = 5'd15,
    CSR_MIDELEG  = 5'd16,
    CSR_MEDELEG  = 5'd17
  } csr_slot_e;

  // rd_sel address map: [GPR, FPR) integer, [FPR, CSR) FP, [CSR, NONE) CSR,
  // NONE and above read as zero.
  localparam logic [6:0] RD_BASE_GPR  = 7'd0;
  localparam logic [6:0] RD_BASE_FPR  = 7'd32;
  localparam logic [6:0] RD_BASE_CSR  = 7'd64;
  localparam logic [6:0] RD_BASE_NONE = 7'd82;

endpackage

// File: rtl/difftest_regbank.sv
// NREG x XLEN capture bank with a combinational read port.
//   clock, reset     : clock, asynchronous active-low reset (clears the bank)
//   capture_en       : load every entry from wr_data on the rising edge
//   wr_data          : packed input vector, entry i in wr_data[i]
//   rd_idx / rd_data : zero-latency read of the stored bank
//   changed          : per entry, wr_data differs from the stored value
// ZERO_ENTRY0 pins entry 0 to zero (hard-wired x0 register).
module difftest_regbank
  import difftest_arch_state_pkg::*;
#(
  parameter int NREG        = NREG_DEF,
  parameter int XLEN        = XLEN_DEF,
  parameter bit ZERO_ENTRY0 = 1'b0,
  localparam int IDX_W      = $clog2(NREG)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       capture_en,
  input  logic [NREG-1:0][XLEN-1:0]  wr_data,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [XLEN-1:0]            rd_data,
  output logic [NREG-1:0]            changed
);

  logic [NREG-1:0][XLEN-1:0] bank_d, bank_q;

  always_comb begin
    bank_d = bank_q;
    if (capture_en) bank_d = wr_data;
    if (ZERO_ENTRY0) bank_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bank_q <= '0;
    else        bank_q <= bank_d;
  end

  // Compared against the stored (pre-capture) value, so a capture reports
  // which entries it is about to modify.
  always_comb begin
    changed = '0;
    for (int i = 0; i < NREG; i++) changed[i] = (wr_data[i] != bank_q[i]);
  end

  assign rd_data = bank_q[rd_idx];

endmodule

// File: rtl/difftest_arch_state.sv
// Architectural-state snapshot for difftest: on capture_en, samples all
// integer/FP registers, 18 CSRs and the hart id in one cycle; the stored
// snapshot is read back through rd_sel/rd_data with zero latency.
//   clock, reset (async, active-low)
//   coreid, capture_en, gpr_0..31, fpr_0..31, CSR inputs : state to capture
//   rd_sel -> rd_data : snapshot read (0-31 gpr, 32-63 fpr, 64-81 CSR, else 0)
//   coreid_q  : captured hart id
//   gpr_dirty : integer entries changed by the last capture (0 when idle)
//   snap_cnt  : captures since reset (wrapping)
//   x0_err    : sticky, a capture saw gpr_0 != 0
module difftest_arch_state
  import difftest_arch_state_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      coreid,
  input  logic            capture_en,
  input  logic [XLEN-1:0] gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7,
                          gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15,
                          gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23,
                          gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31,
  input  logic [XLEN-1:0] fpr_0,  fpr_1,  fpr_2,  fpr_3,  fpr_4,  fpr_5,  fpr_6,  fpr_7,
                          fpr_8,  fpr_9,  fpr_10, fpr_11, fpr_12, fpr_13, fpr_14, fpr_15,
                          fpr_16, fpr_17, fpr_18, fpr_19, fpr_20, fpr_21, fpr_22, fpr_23,
                          fpr_24, fpr_25, fpr_26, fpr_27, fpr_28, fpr_29, fpr_30, fpr_31,
  input  logic [XLEN-1:0] priviledgeMode, mstatus, sstatus, mepc, sepc, mtval, stval,
                          mtvec, stvec, mcause, scause, satp, mip, mie, mscratch,
                          sscratch, mideleg, medeleg,
  input  logic [6:0]      rd_sel,
  output logic [XLEN-1:0] rd_data,
  output logic [7:0]      coreid_q,
  output logic [31:0]     gpr_dirty,
  output logic [31:0]     snap_cnt,
  output logic            x0_err
);

  localparam int IDX_W = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0]      gpr_vec, fpr_vec;
  logic [CSR_SLOTS-1:0][XLEN-1:0] csr_in, csr_d, csr_q;
  logic [NREG-1:0]                gpr_changed, fpr_changed_unused;
  logic [XLEN-1:0]                gpr_rd, fpr_rd;
  logic [4:0]                     csr_off;
  logic [7:0]                     coreid_d;
  logic [31:0]                    gpr_dirty_d, gpr_dirty_q;
  logic [31:0]                    snap_cnt_d, snap_cnt_q;
  logic                           x0_err_d, x0_err_q;

  assign gpr_vec = {gpr_31, gpr_30, gpr_29, gpr_28, gpr_27, gpr_26, gpr_25, gpr_24,
                    gpr_23, gpr_22, gpr_21, gpr_20, gpr_19, gpr_18, gpr_17, gpr_16,
                    gpr_15, gpr_14, gpr_13, gpr_12, gpr_11, gpr_10, gpr_9,  gpr_8,
                    gpr_7,  gpr_6,  gpr_5,  gpr_4,  gpr_3,  gpr_2,  gpr_1,  gpr_0};
  assign fpr_vec = {fpr_31, fpr_30, fpr_29, fpr_28, fpr_27, fpr_26, fpr_25, fpr_24,
                    fpr_23, fpr_22, fpr_21, fpr_20, fpr_19, fpr_18, fpr_17, fpr_16,
                    fpr_15, fpr_14, fpr_13, fpr_12, fpr_11, fpr_10, fpr_9,  fpr_8,
                    fpr_7,  fpr_6,  fpr_5,  fpr_4,  fpr_3,  fpr_2,  fpr_1,  fpr_0};

  assign csr_in[CSR_PRIV]     = priviledgeMode;
  assign csr_in[CSR_MSTATUS]  = mstatus;
  assign csr_in[CSR_SSTATUS]  = sstatus;
  assign csr_in[CSR_MEPC]     = mepc;
  assign csr_in[CSR_SEPC]     = sepc;
  assign csr_in[CSR_MTVAL]    = mtval;
  assign csr_in[CSR_STVAL]    = stval;
  assign csr_in[CSR_MTVEC]    = mtvec;
  assign csr_in[CSR_STVEC]    = stvec;
  assign csr_in[CSR_MCAUSE]   = mcause;
  assign csr_in[CSR_SCAUSE]   = scause;
  assign csr_in[CSR_SATP]     = satp;
  assign csr_in[CSR_MIP]      = mip;
  assign csr_in[CSR_MIE]      = mie;
  assign csr_in[CSR_MSCRATCH] = mscratch;
  assign csr_in[CSR_SSCRATCH] = sscratch;
  assign csr_in[CSR_MIDELEG]  = mideleg;
  assign csr_in[CSR_MEDELEG]  = medeleg;

  difftest_regbank #(.NREG(NREG), .XLEN(XLEN), .ZERO_ENTRY0(1'b1)) u_gpr_bank (
    .clock      (clock),
    .reset      (reset),
    .capture_en (capture_en),
    .wr_data    (gpr_vec),
    .rd_idx     (rd_sel[IDX_W-1:0]),
    .rd_data    (gpr_rd),
    .changed    (gpr_changed)
  );

  difftest_regbank #(.NREG(NREG), .XLEN(XLEN), .ZERO_ENTRY0(1'b0)) u_fpr_bank (
    .clock      (clock),
    .reset      (reset),
    .capture_en (capture_en),
    .wr_data    (fpr_vec),
    .rd_idx     (rd_sel[IDX_W-1:0]),
    .rd_data    (fpr_rd),
    .changed    (fpr_changed_unused)
  );

  always_comb begin
    csr_d       = csr_q;
    coreid_d    = coreid_q;
    snap_cnt_d  = snap_cnt_q;
    gpr_dirty_d = '0;
    x0_err_d    = x0_err_q;
    if (capture_en) begin
      csr_d       = csr_in;
      coreid_d    = coreid;
      snap_cnt_d  = snap_cnt_q + 32'd1;
      // Entry 0 is hard-wired to zero, so it never counts as modified.
      gpr_dirty_d = 32'(gpr_changed) & ~32'd1;
      x0_err_d    = x0_err_q | (gpr_0 != '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csr_q       <= '0;
      coreid_q    <= '0;
      snap_cnt_q  <= '0;
      gpr_dirty_q <= '0;
      x0_err_q    <= 1'b0;
    end else begin
      csr_q       <= csr_d;
      coreid_q    <= coreid_d;
      snap_cnt_q  <= snap_cnt_d;
      gpr_dirty_q <= gpr_dirty_d;
      x0_err_q    <= x0_err_d;
    end
  end

  // CSR region base is 64, so the slot index is just the low bits of rd_sel.
  assign csr_off = rd_sel[4:0] - RD_BASE_CSR[4:0];

  always_comb begin
    rd_data = '0;
    if (rd_sel < RD_BASE_FPR)       rd_data = gpr_rd;
    else if (rd_sel < RD_BASE_CSR)  rd_data = fpr_rd;
    else if (rd_sel < RD_BASE_NONE) rd_data = csr_q[csr_off];
  end

  assign gpr_dirty = gpr_dirty_q;
  assign snap_cnt  = snap_cnt_q;
  assign x0_err    = x0_err_q;

endmodule

// File: tb/tb_difftest_arch_state.sv
module tb_difftest_arch_state;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  coreid = 8'd0;
  logic        capture_en = 1'b0;
  logic [63:0] gpr [32];
  logic [63:0] fpr [32];
  logic [63:0] csr [18];
  logic [6:0]  rd_sel = 7'd0;
  logic [63:0] rd_data;
  logic [7:0]  coreid_q;
  logic [31:0] gpr_dirty;
  logic [31:0] snap_cnt;
  logic        x0_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  difftest_arch_state dut (
    .clock(clock), .reset(reset), .coreid(coreid), .capture_en(capture_en),
    .gpr_0(gpr[0]),   .gpr_1(gpr[1]),   .gpr_2(gpr[2]),   .gpr_3(gpr[3]),
    .gpr_4(gpr[4]),   .gpr_5(gpr[5]),   .gpr_6(gpr[6]),   .gpr_7(gpr[7]),
    .gpr_8(gpr[8]),   .gpr_9(gpr[9]),   .gpr_10(gpr[10]), .gpr_11(gpr[11]),
    .gpr_12(gpr[12]), .gpr_13(gpr[13]), .gpr_14(gpr[14]), .gpr_15(gpr[15]),
    .gpr_16(gpr[16]), .gpr_17(gpr[17]), .gpr_18(gpr[18]), .gpr_19(gpr[19]),
    .gpr_20(gpr[20]), .gpr_21(gpr[21]), .gpr_22(gpr[22]), .gpr_23(gpr[23]),
    .gpr_24(gpr[24]), .gpr_25(gpr[25]), .gpr_26(gpr[26]), .gpr_27(gpr[27]),
    .gpr_28(gpr[28]), .gpr_29(gpr[29]), .gpr_30(gpr[30]), .gpr_31(gpr[31]),
    .fpr_0(fpr[0]),   .fpr_1(fpr[1]),   .fpr_2(fpr[2]),   .fpr_3(fpr[3]),
    .fpr_4(fpr[4]),   .fpr_5(fpr[5]),   .fpr_6(fpr[6]),   .fpr_7(fpr[7]),
    .fpr_8(fpr[8]),   .fpr_9(fpr[9]),   .fpr_10(fpr[10]), .fpr_11(fpr[11]),
    .fpr_12(fpr[12]), .fpr_13(fpr[13]), .fpr_14(fpr[14]), .fpr_15(fpr[15]),
    .fpr_16(fpr[16]), .fpr_17(fpr[17]), .fpr_18(fpr[18]), .fpr_19(fpr[19]),
    .fpr_20(fpr[20]), .fpr_21(fpr[21]), .fpr_22(fpr[22]), .fpr_23(fpr[23]),
    .fpr_24(fpr[24]), .fpr_25(fpr[25]), .fpr_26(fpr[26]), .fpr_27(fpr[27]),
    .fpr_28(fpr[28]), .fpr_29(fpr[29]), .fpr_30(fpr[30]), .fpr_31(fpr[31]),
    .priviledgeMode(csr[0]), .mstatus(csr[1]),   .sstatus(csr[2]),   .mepc(csr[3]),
    .sepc(csr[4]),           .mtval(csr[5]),     .stval(csr[6]),     .mtvec(csr[7]),
    .stvec(csr[8]),          .mcause(csr[9]),    .scause(csr[10]),   .satp(csr[11]),
    .mip(csr[12]),           .mie(csr[13]),      .mscratch(csr[14]), .sscratch(csr[15]),
    .mideleg(csr[16]),       .medeleg(csr[17]),
    .rd_sel(rd_sel), .rd_data(rd_data), .coreid_q(coreid_q),
    .gpr_dirty(gpr_dirty), .snap_cnt(snap_cnt), .x0_err(x0_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [6:0] sel, input logic [63:0] exp, input string tag);
    rd_sel = sel;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // One capture cycle; returns 1 ns after the capturing edge.
  task automatic capture();
    @(negedge clock);
    capture_en = 1'b1;
    @(posedge clock);
    #1;
    capture_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin gpr[i] = '0; fpr[i] = '0; end
    for (int i = 0; i < 18; i++) csr[i] = '0;

    // Reset state
    #1;
    chk("rst_snap_cnt", 64'(snap_cnt), 64'd0);
    chk("rst_x0_err",   64'(x0_err), 64'd0);
    chk("rst_dirty",    64'(gpr_dirty), 64'd0);
    chk("rst_coreid",   64'(coreid_q), 64'd0);
    rd(7'd5, 64'd0, "rst_rd5");
    @(negedge clock);
    reset = 1'b1;

    // Basic capture across all three regions
    gpr[5] = 64'h1234; fpr[7] = 64'hDEAD; csr[3] = 64'h8000_0000;
    csr[2] = 64'h0000_00AA; csr[0] = 64'd3; csr[17] = 64'h5A5A;
    fpr[31] = 64'h77; coreid = 8'd3;
    capture();
    rd(7'd5,  64'h1234, "cap_gpr5");
    rd(7'd39, 64'hDEAD, "cap_fpr7");
    rd(7'd67, 64'h8000_0000, "cap_mepc");
    rd(7'd66, 64'hAA, "cap_sstatus");
    rd(7'd63, 64'h77, "cap_fpr31");
    rd(7'd81, 64'h5A5A, "cap_medeleg");
    rd(7'd82, 64'd0, "cap_sel82");
    chk("cap_snap_cnt", 64'(snap_cnt), 64'd1);
    chk("cap_coreid",   64'(coreid_q), 64'd3);
    chk("cap_dirty",    64'(gpr_dirty), 64'h20);

    // x0 handling
    gpr[0] = 64'hFF;
    capture();
    rd(7'd0, 64'd0, "x0_rd");
    chk("x0_err_set", 64'(x0_err), 64'd1);
    chk("x0_dirty",   64'(gpr_dirty), 64'd0);
    gpr[0] = 64'd0;
    capture();
    chk("x0_err_sticky", 64'(x0_err), 64'd1);
    chk("x0_snap_cnt",   64'(snap_cnt), 64'd3);

    // Dirty tracking
    gpr[3] = 64'd1;
    capture();
    gpr[3] = 64'd2;
    capture();
    chk("dirty_gpr3", 64'(gpr_dirty), 64'h8);
    rd(7'd3, 64'd2, "dirty_rd3");
    @(posedge clock); #1;
    chk("dirty_idle", 64'(gpr_dirty), 64'd0);

    // Ten idle cycles with changing inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      gpr[5] = 64'(i + 100); fpr[7] = 64'(i); csr[3] = 64'(i * 7); coreid = 8'(i + 40);
    end
    @(posedge clock); #1;
    rd(7'd5,  64'h1234, "idle_gpr5");
    rd(7'd39, 64'hDEAD, "idle_fpr7");
    rd(7'd67, 64'h8000_0000, "idle_mepc");
    rd(7'd100, 64'd0, "idle_sel100");
    chk("idle_snap_cnt", 64'(snap_cnt), 64'd5);
    chk("idle_coreid",   64'(coreid_q), 64'd3);

    // Asynchronous reset mid-operation
    gpr[7] = 64'h99;
    capture(); capture();
    gpr[7] = 64'h98;
    capture();
    chk("pre_rst_snap_cnt", 64'(snap_cnt), 64'd8);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_snap_cnt", 64'(snap_cnt), 64'd0);
    chk("arst_x0_err",   64'(x0_err), 64'd0);
    chk("arst_coreid",   64'(coreid_q), 64'd0);
    chk("arst_dirty",    64'(gpr_dirty), 64'd0);
    rd(7'd7,  64'd0, "arst_gpr7");
    rd(7'd39, 64'd0, "arst_fpr7");
    rd(7'd64, 64'd0, "arst_priv");
    @(negedge clock);
    reset = 1'b1;
    csr[0] = 64'd3;
    capture();
    chk("post_rst_snap_cnt", 64'(snap_cnt), 64'd1);
    chk("post_rst_x0_err",   64'(x0_err), 64'd0);

    // Counter wrap and read-before-capture
    @(negedge clock);
    force dut.snap_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.snap_cnt_q;
    #1;
    chk("wrap_preload", 64'(snap_cnt), 64'hFFFF_FFFF);
    @(negedge clock);
    csr[0] = 64'd1;
    capture_en = 1'b1;
    rd(7'd64, 64'd3, "same_cycle_priv");
    @(posedge clock); #1;
    capture_en = 1'b0;
    chk("wrap_snap_cnt", 64'(snap_cnt), 64'd0);
    rd(7'd64, 64'd1, "after_edge_priv");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
